// File: rtl/cp0_exc_ctrl_if.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl_if
// M-stage side of the coprocessor-0 exception controller.
//   master : pipeline (drives M-stage instruction info, interrupt lines,
//            mtc0/mfc0 requests; receives redirect and read data)
//   slave  : cp0_exc_ctrl
// Signals:
//   M_pc, M_bd, M_exc_valid, M_exc_code   M-stage instruction status
//   HWInt                                 level-sensitive interrupt lines
//   M_eret, M_mtc0_we, M_cp0_addr,
//   M_cp0_wdata                           eret / mtc0 / mfc0 controls
//   M_cp0_rdata                           mfc0 read data
//   req, handler_pc, epc_out, exl_out     flush/redirect outputs
// ---------------------------------------------------------------------------
interface cp0_exc_ctrl_if;
  logic [31:0] M_pc;
  logic        M_bd;
  logic        M_exc_valid;
  logic [4:0]  M_exc_code;
  logic [5:0]  HWInt;
  logic        M_eret;
  logic        M_mtc0_we;
  logic [4:0]  M_cp0_addr;
  logic [31:0] M_cp0_wdata;
  logic [31:0] M_cp0_rdata;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;
  logic        exl_out;

  modport master (
    output M_pc, M_bd, M_exc_valid, M_exc_code, HWInt,
           M_eret, M_mtc0_we, M_cp0_addr, M_cp0_wdata,
    input  M_cp0_rdata, req, handler_pc, epc_out, exl_out
  );

  modport slave (
    input  M_pc, M_bd, M_exc_valid, M_exc_code, HWInt,
           M_eret, M_mtc0_we, M_cp0_addr, M_cp0_wdata,
    output M_cp0_rdata, req, handler_pc, epc_out, exl_out
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
// Coprocessor-0 exception controller for the M stage. Holds SR(12),
// Cause(13), EPC(14) and a read-only PRId(15). Merges the M-stage synchronous
// exception with masked hardware interrupts into a single combinational
// request, records exception state on it, and leaves the handler on eret.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    cp0_exc_ctrl_if.slave (M-stage inputs, redirect + mfc0 outputs)
// Parameters:
//   HANDLER_ADDR  handler entry PC driven on handler_pc
//   PRID_VALUE    read-only PRId contents
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  cp0_exc_ctrl_if.slave  bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;
  localparam logic [4:0] EXC_ADEL   = 5'd4;

  // The controller state is SR.EXL itself: NORMAL (EXL=0), HANDLER (EXL=1).
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [5:0]  ip_q;
  logic [31:0] epc_q, epc_d;
  logic [31:0] last_pc_q;

  logic        exl;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        mtc0_sr;
  logic        mtc0_epc;
  logic [31:0] pc_src;
  logic [31:0] epc_raw;
  logic [31:0] epc_exc;

  assign exl     = (state_q == HANDLER);
  assign int_req = (|(bus.HWInt & im_q)) & ie_q & ~exl;
  assign exc_req = bus.M_exc_valid & ~exl;
  // Held low during reset so a stray M_exc_valid cannot flush the pipe.
  assign req     = ~reset & (int_req | exc_req);

  // mtc0 loses to a same-cycle exception request.
  assign mtc0_sr  = bus.M_mtc0_we & (bus.M_cp0_addr == ADDR_SR)  & ~req;
  assign mtc0_epc = bus.M_mtc0_we & (bus.M_cp0_addr == ADDR_EPC) & ~req;

  // A bubble (M_pc==0) has no PC of its own; use the last real one.
  assign pc_src  = (bus.M_pc != 32'd0) ? bus.M_pc : last_pc_q;
  assign epc_raw = bus.M_bd ? (pc_src - 32'd4) : pc_src;
  // Only a fetch address error keeps the misaligned low bits, so the
  // handler can see the bad PC. Load AdEL has an aligned PC anyway.
  assign epc_exc = (!int_req && bus.M_exc_code == EXC_ADEL) ?
                   epc_raw : {epc_raw[31:2], 2'b00};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    im_d       = im_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (req) begin
      state_d    = HANDLER;
      exc_code_d = int_req ? 5'd0 : bus.M_exc_code;
      bd_d       = bus.M_bd;
      epc_d      = epc_exc;
    end else begin
      if (mtc0_sr) begin
        im_d    = bus.M_cp0_wdata[15:10];
        ie_d    = bus.M_cp0_wdata[0];
        state_d = bus.M_cp0_wdata[1] ? HANDLER : NORMAL;
      end
      if (mtc0_epc) begin
        epc_d = bus.M_cp0_wdata;
      end
      // eret is applied after a same-cycle mtc0 SR, so EXL ends up cleared.
      if (bus.M_eret && exl) begin
        state_d = NORMAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= NORMAL;
      im_q       <= '0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_q       <= '0;
      epc_q      <= '0;
      last_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      im_q       <= im_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_q       <= bus.HWInt;
      epc_q      <= epc_d;
      if (bus.M_pc != 32'd0) begin
        last_pc_q <= bus.M_pc;
      end
    end
  end

  assign bus.req        = req;
  assign bus.handler_pc = HANDLER_ADDR;
  assign bus.exl_out    = exl & ~reset;
  // Bypass lets an eret issued together with mtc0 EPC return to the new value.
  assign bus.epc_out    = reset    ? 32'd0 :
                          mtc0_epc ? bus.M_cp0_wdata : epc_q;

  always_comb begin
    bus.M_cp0_rdata = 32'd0;
    if (!reset) begin
      case (bus.M_cp0_addr)
        ADDR_SR:    bus.M_cp0_rdata = {16'd0, im_q, 8'd0, exl, ie_q};
        ADDR_CAUSE: bus.M_cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
        ADDR_EPC:   bus.M_cp0_rdata = epc_q;
        ADDR_PRID:  bus.M_cp0_rdata = PRID_VALUE;
        default:    bus.M_cp0_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
// Directed bench for cp0_exc_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h0001_8000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #10 clk = ~clk;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(
    .HANDLER_ADDR (32'h0000_4180),
    .PRID_VALUE   (PRID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clear per-instruction controls; M_pc and HWInt are left to the caller.
  task automatic set_idle();
    bus.M_bd        = 1'b0;
    bus.M_exc_valid = 1'b0;
    bus.M_exc_code  = 5'd0;
    bus.M_eret      = 1'b0;
    bus.M_mtc0_we   = 1'b0;
    bus.M_cp0_addr  = 5'd0;
    bus.M_cp0_wdata = 32'd0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.M_cp0_addr = a;
    #1;
    d = bus.M_cp0_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    @(negedge clk);
    reset = 1'b1; set_idle(); bus.M_pc = 32'h0; bus.HWInt = 6'd0;
    bus.M_exc_valid = 1'b1; bus.M_cp0_addr = 5'd15;
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_req_in_reset: got %b want 0", bus.req); end
    n_cmp++; if (bus.M_cp0_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata_in_reset: got %h want 0", bus.M_cp0_rdata); end
    @(negedge clk);
    reset = 1'b0; set_idle();
    rd(5'd12, d); n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_sr: got %h want 0", d); end
    rd(5'd13, d); n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_cause: got %h want 0", d); end
    rd(5'd14, d); n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_epc: got %h want 0", d); end
    rd(5'd15, d); n_cmp++; if (d !== PRID) begin n_bad++; $display("FAIL rst_prid: got %h want %h", d, PRID); end
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.req); end
    n_cmp++; if (bus.exl_out !== 1'b0) begin n_bad++; $display("FAIL rst_exl: got %b want 0", bus.exl_out); end
    n_cmp++; if (bus.epc_out !== 32'd0) begin n_bad++; $display("FAIL rst_epc_out: got %h want 0", bus.epc_out); end
    n_cmp++; if (bus.handler_pc !== 32'h0000_4180) begin n_bad++; $display("FAIL handler_pc: got %h want 00004180", bus.handler_pc); end
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    @(negedge clk);
    set_idle(); bus.M_pc = 32'h3000; bus.HWInt = 6'd0;
    bus.M_mtc0_we = 1'b1; bus.M_cp0_addr = 5'd12; bus.M_cp0_wdata = 32'h0000_0401;
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL int_sr_write_req: got %b want 0", bus.req); end
    @(negedge clk);
    set_idle(); bus.M_pc = 32'h3010; bus.HWInt = 6'b000001;
    #1;
    n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL int_req: got %b want 1", bus.req); end
    @(negedge clk);
    set_idle(); bus.M_pc = 32'h3014;
    #1;
    n_cmp++; if (bus.exl_out !== 1'b1) begin n_bad++; $display("FAIL int_exl: got %b want 1", bus.exl_out); end
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL int_req_masked_by_exl: got %b want 0", bus.req); end
    rd(5'd12, d); n_cmp++; if (d !== 32'h0000_0403) begin n_bad++; $display("FAIL int_sr: got %h want 00000403", d); end
    rd(5'd13, d); n_cmp++; if (d !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause: got %h want 00000400", d); end
    rd(5'd14, d); n_cmp++; if (d !== 32'h0000_3010) begin n_bad++; $display("FAIL int_epc: got %h want 00003010", d); end
  endtask

  task automatic test_exception_bd();
    logic [31:0] d;
    @(negedge clk);
    set_idle(); bus.HWInt = 6'd0; bus.M_eret = 1'b1;
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL eret1_req: got %b want 0", bus.req); end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++; if (bus.exl_out !== 1'b0) begin n_bad++; $display("FAIL eret1_exl: got %b want 0", bus.exl_out); end
    n_cmp++; if (bus.epc_out !== 32'h3010) begin n_bad++; $display("FAIL eret1_epc_out: got %h want 00003010", bus.epc_out); end
    @(negedge clk);
    set_idle(); bus.M_exc_valid = 1'b1; bus.M_exc_code = 5'd8; bus.M_pc = 32'h3020; bus.M_bd = 1'b1;
    #1;
    n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL exc_req: got %b want 1", bus.req); end
    @(negedge clk);
    set_idle(); bus.M_pc = 32'h3024;
    #1;
    n_cmp++; if (bus.exl_out !== 1'b1) begin n_bad++; $display("FAIL exc_exl: got %b want 1", bus.exl_out); end
    rd(5'd14, d); n_cmp++; if (d !== 32'h0000_301C) begin n_bad++; $display("FAIL exc_bd_epc: got %h want 0000301c", d); end
    rd(5'd13, d); n_cmp++; if (d !== 32'h8000_0020) begin n_bad++; $display("FAIL exc_bd_cause: got %h want 80000020", d); end
    @(negedge clk);
    set_idle(); bus.M_eret = 1'b1;
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++; if (bus.exl_out !== 1'b0) begin n_bad++; $display("FAIL eret2_exl: got %b want 0", bus.exl_out); end
    n_cmp++; if (bus.epc_out !== 32'h301C) begin n_bad++; $display("FAIL eret2_epc_out: got %h want 0000301c", bus.epc_out); end
  endtask

  task automatic test_adel();
    logic [31:0] d;
    @(negedge clk);
    set_idle(); bus.M_exc_valid = 1'b1; bus.M_exc_code = 5'd4; bus.M_pc = 32'h3035;
    @(negedge clk);
    set_idle(); bus.M_pc = 32'h3038;
    rd(5'd14, d); n_cmp++; if (d !== 32'h0000_3035) begin n_bad++; $display("FAIL adel_epc: got %h want 00003035", d); end
    rd(5'd13, d); n_cmp++; if (d !== 32'h0000_0010) begin n_bad++; $display("FAIL adel_cause: got %h want 00000010", d); end
    @(negedge clk);
    set_idle(); bus.M_eret = 1'b1;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_int_vs_exc();
    logic [31:0] d;
    @(negedge clk);
    set_idle(); bus.HWInt = 6'b000001; bus.M_pc = 32'h3032;
    bus.M_exc_valid = 1'b1; bus.M_exc_code = 5'd12;
    bus.M_mtc0_we = 1'b1; bus.M_cp0_addr = 5'd14; bus.M_cp0_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL ivx_req: got %b want 1", bus.req); end
    n_cmp++; if (bus.epc_out !== 32'h3035) begin n_bad++; $display("FAIL ivx_no_bypass: got %h want 00003035", bus.epc_out); end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL ivx_req_in_handler: got %b want 0", bus.req); end
    rd(5'd14, d); n_cmp++; if (d !== 32'h0000_3030) begin n_bad++; $display("FAIL ivx_epc: got %h want 00003030", d); end
    rd(5'd13, d); n_cmp++; if (d !== 32'h0000_0400) begin n_bad++; $display("FAIL ivx_cause: got %h want 00000400", d); end
  endtask

  task automatic test_eret_mtc0();
    logic [31:0] d;
    @(negedge clk);
    set_idle(); bus.HWInt = 6'd0; bus.M_eret = 1'b1;
    bus.M_mtc0_we = 1'b1; bus.M_cp0_addr = 5'd14; bus.M_cp0_wdata = 32'h0000_3100;
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL em_req: got %b want 0", bus.req); end
    n_cmp++; if (bus.epc_out !== 32'h3100) begin n_bad++; $display("FAIL em_bypass: got %h want 00003100", bus.epc_out); end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++; if (bus.exl_out !== 1'b0) begin n_bad++; $display("FAIL em_exl: got %b want 0", bus.exl_out); end
    n_cmp++; if (bus.epc_out !== 32'h3100) begin n_bad++; $display("FAIL em_epc_out: got %h want 00003100", bus.epc_out); end
    rd(5'd14, d); n_cmp++; if (d !== 32'h0000_3100) begin n_bad++; $display("FAIL em_epc: got %h want 00003100", d); end
    // Enter the handler again, then write SR together with eret.
    @(negedge clk);
    set_idle(); bus.M_exc_valid = 1'b1; bus.M_exc_code = 5'd10; bus.M_pc = 32'h3050;
    @(negedge clk);
    set_idle(); bus.M_eret = 1'b1;
    bus.M_mtc0_we = 1'b1; bus.M_cp0_addr = 5'd12; bus.M_cp0_wdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (bus.exl_out !== 1'b1) begin n_bad++; $display("FAIL sr_eret_pre_exl: got %b want 1", bus.exl_out); end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++; if (bus.exl_out !== 1'b0) begin n_bad++; $display("FAIL sr_eret_exl: got %b want 0", bus.exl_out); end
    rd(5'd12, d); n_cmp++; if (d !== 32'h0000_FC01) begin n_bad++; $display("FAIL sr_eret_sr: got %h want 0000fc01", d); end
  endtask

  task automatic test_bubble();
    logic [31:0] d;
    @(negedge clk);
    set_idle(); bus.HWInt = 6'd0; bus.M_pc = 32'h3040;
    bus.M_mtc0_we = 1'b1; bus.M_cp0_addr = 5'd13; bus.M_cp0_wdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL bub_cause_wr_req: got %b want 0", bus.req); end
    @(negedge clk);
    set_idle(); bus.M_pc = 32'h0;
    bus.M_mtc0_we = 1'b1; bus.M_cp0_addr = 5'd15; bus.M_cp0_wdata = 32'h1234_5678;
    @(negedge clk);
    set_idle(); bus.M_pc = 32'h0; bus.HWInt = 6'b100000;
    #1;
    n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL bub_req: got %b want 1", bus.req); end
    rd(5'd13, d); n_cmp++; if (d !== 32'h0000_0028) begin n_bad++; $display("FAIL cause_wr_dropped: got %h want 00000028", d); end
    rd(5'd15, d); n_cmp++; if (d !== PRID) begin n_bad++; $display("FAIL prid_wr_dropped: got %h want %h", d, PRID); end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++; if (bus.exl_out !== 1'b1) begin n_bad++; $display("FAIL bub_exl: got %b want 1", bus.exl_out); end
    rd(5'd14, d); n_cmp++; if (d !== 32'h0000_3040) begin n_bad++; $display("FAIL bub_epc: got %h want 00003040", d); end
    rd(5'd13, d); n_cmp++; if (d !== 32'h0000_8000) begin n_bad++; $display("FAIL bub_cause: got %h want 00008000", d); end
  endtask

  task automatic test_reset_in_handler();
    logic [31:0] d;
    @(negedge clk);
    set_idle(); bus.HWInt = 6'd0; reset = 1'b1;
    #1;
    n_cmp++; if (bus.exl_out !== 1'b0) begin n_bad++; $display("FAIL rh_exl_in_reset: got %b want 0", bus.exl_out); end
    @(negedge clk);
    reset = 1'b0; set_idle();
    #1;
    n_cmp++; if (bus.exl_out !== 1'b0) begin n_bad++; $display("FAIL rh_exl: got %b want 0", bus.exl_out); end
    rd(5'd12, d); n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rh_sr: got %h want 0", d); end
    rd(5'd13, d); n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rh_cause: got %h want 0", d); end
    rd(5'd14, d); n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rh_epc: got %h want 0", d); end
  endtask

  initial begin
    reset = 1'b1;
    bus.M_pc = 32'd0;
    bus.HWInt = 6'd0;
    set_idle();
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_adel();
    test_int_vs_exc();
    test_eret_mtc0();
    test_bubble();
    test_reset_in_handler();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
